fractal_ctrl_axil_slave: RTL and testbench
==========================================

// Module: fractal_ctrl_axil_slave
// PURPOSE
//  AXI4-Lite responder holding the fractal generator's parameters (x0,y0,dx,dy,cr,ci) and control.
//  Sits between the PS/VIP AXI4-Lite master and the fractal core.
//  Writes land in pending registers; the core sees active (shadow) copies updated only at frame start,
//  so a frame is never rendered with mixed parameters.
// PARAMETERS
//  ADDR_W   6   AXI4-Lite address width (byte address; bits[1:0] ignored)
//  DATA_W   32  AXI4-Lite data width; only 32 supported
// PORTS
//  aclk           in   1   clock
//  aresetn        in   1   asynchronous active-low reset
//  s_axi_awaddr   in   6   write address
//  s_axi_awvalid  in   1   / s_axi_awready out 1   AW handshake
//  s_axi_wdata    in   32  write data
//  s_axi_wstrb    in   4   byte enables
//  s_axi_wvalid   in   1   / s_axi_wready  out 1   W handshake
//  s_axi_bresp    out  2   OKAY=00, SLVERR=10
//  s_axi_bvalid   out  1   / s_axi_bready  in  1   B handshake
//  s_axi_araddr   in   6   read address
//  s_axi_arvalid  in   1   / s_axi_arready out 1   AR handshake
//  s_axi_rdata    out  32  read data
//  s_axi_rresp    out  2   OKAY=00, SLVERR=10
//  s_axi_rvalid   out  1   / s_axi_rready  in  1   R handshake
//  frame_start    in   1   one-cycle pulse from core, coincident with first pixel (tuser)
//  run            out  1   active ctrl[0]; core generates frames while 1
//  palette        out  3   active ctrl[10:8]
//  x0,y0,dx,dy,cr,ci out 32 each  active Q4.28 signed parameters
// BEHAVIOUR
//  Map: 0x00 ctrl RW {bits[10:8] palette, bit0 run}; 0x08 frame count RO; 0x10 x0; 0x18 y0; 0x20 dx;
//   0x28 dy; 0x30 cr; 0x38 ci (all RW). Unused ctrl bits read 0. Any other address -> SLVERR,
//   write discarded, read data 0.
//  Reset: all pending/active regs 0, all *ready/*valid 0, bresp/rresp 00, rdata 0, frame count 0.
//  Write FSM W_IDLE -> W_RESP: awready/wready high in W_IDLE; AW and W captured independently, either
//   order or same cycle; when both held, register update + bvalid=1 next cycle (W_RESP).
//   awready/wready low in W_RESP. bvalid held until bready; then W_IDLE. One outstanding write.
//  WSTRB: per-byte update; wstrb=0 -> OKAY, no change.
//  Read FSM R_IDLE -> R_DATA: arready high in R_IDLE; rdata/rvalid registered 1 cycle after AR handshake,
//   held stable until rready. Reads return pending (not active) values.
//  Same-cycle write and read of same reg: read returns pre-write value.
//  Active update: run_pending=0 -> active copies track pending every cycle (1-cycle lag).
//   run_pending=1 -> all active copies load from pending only on frame_start; run itself always
//   tracks pending ctrl[0] with 1-cycle lag (so start and stop take effect immediately).
//  Write committing in same cycle as frame_start: active loads the old pending value; new value
//   applied at next frame_start.
//  Frame count: 32-bit, +1 per frame_start while run=1, wraps 0xFFFFFFFF -> 0; write to 0x08 -> SLVERR.
//  Reset asserted mid-transaction: FSMs return to idle, valids drop asynchronously; master must reissue.
// CONFIGURATION
//  FRACTAL_CTRL_FRAME_CNT_EN defined: 0x08 frame counter implemented as above.
//  Not defined: no counter logic; 0x08 reads 0 with OKAY, writes to 0x08 -> SLVERR.
// TESTING
//  Reset, then read every mapped addr -> rdata 0, rresp 00; all active outputs 0, run=0.
//  Write 0x10=0x10000000, 0x18=0x09000000, 0x30=0xF9999999 with run=0 -> outputs follow within 2 cycles, bresp 00.
//  Write ctrl=0x701, then x0=0x20000000 -> x0 output stays 0x10000000 until frame_start pulse,
//   then 0x20000000; palette=7, run=1.
//  AW 10 cycles before W, then W before AW, bready held low 5 cycles -> single update each,
//   bvalid stable until bready.
//  Write 0x3C and read 0x04 -> SLVERR both, no register change; wstrb=0x3 to 0x20 -> only [15:0] updated.
//  (FRACTAL_CTRL_FRAME_CNT_EN) 3 frame_start pulses with run=1, 1 with run=0 -> 0x08 reads 3;
//   assert aresetn mid read -> rvalid 0 immediately, counter 0.

Source files
------------

// File: rtl/fractal_ctrl_axil_slave.sv
// fractal_ctrl_axil_slave: AXI4-Lite register block for the fractal core.
// Optional 0x08 frame counter: define FRACTAL_CTRL_FRAME_CNT_EN.
module fractal_ctrl_axil_slave #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic              frame_start,
  output logic              run,
  output logic [2:0]        palette,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] dx,
  output logic [DATA_W-1:0] dy,
  output logic [DATA_W-1:0] cr,
  output logic [DATA_W-1:0] ci
);

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                live;
  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic                aw_hs, w_hs, ar_hs, wr_go, wr_bad;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic [2:0]          wr_idx, rd_idx;
  logic [DATA_W-1:0]   rd_val;
  logic                unused_addr;

  logic                pend_run, act_run;
  logic [2:0]          pend_pal, act_pal;
  logic [DATA_W-1:0]   pend_p [6];
  logic [DATA_W-1:0]   act_p  [6];
  logic [DATA_W-1:0]   frame_cnt;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0]   old,
    input logic [DATA_W-1:0]   nw,
    input logic [DATA_W/8-1:0] strb
  );
    merge = old;
    for (int b = 0; b < DATA_W/8; b++)
      if (strb[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held ? w_strb_q : s_axi_wstrb;
  assign wr_idx  = wr_addr[5:3];
  assign rd_idx  = s_axi_araddr[5:3];
  assign wr_bad  = wr_addr[2] | (wr_idx == 3'd1);
  assign wr_go   = (wr_state == W_IDLE) & (aw_held | aw_hs)
                 & (w_held | w_hs);
  assign unused_addr = ^{wr_addr[1:0], s_axi_araddr[1:0]};

  // Readies stay low until the first clock after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_next;
  end

  // Write FSM next state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_go) wr_next = W_RESP;
      W_RESP:  if (s_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Write FSM outputs; a captured channel stops accepting until commit
  always_comb begin
    s_axi_awready = live & (wr_state == W_IDLE) & ~aw_held;
    s_axi_wready  = live & (wr_state == W_IDLE) & ~w_held;
    s_axi_bvalid  = (wr_state == W_RESP);
  end

  // Hold AW and W independently until both have arrived
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (wr_go) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
    end
  end

  // Pending register update and write response code
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend_run    <= 1'b0;
      pend_pal    <= '0;
      s_axi_bresp <= 2'b00;
      for (int i = 0; i < 6; i++) pend_p[i] <= '0;
    end else if (wr_go) begin
      s_axi_bresp <= wr_bad ? 2'b10 : 2'b00;
      if (!wr_bad) begin
        if (wr_idx == 3'd0) begin
          if (wr_strb[0]) pend_run <= wr_data[0];
          if (wr_strb[1]) pend_pal <= wr_data[10:8];
        end
        for (int i = 0; i < 6; i++)
          if (wr_idx == 3'(i + 2))
            pend_p[i] <= merge(pend_p[i], wr_data, wr_strb);
      end
    end
  end

  // Shadow copies: free-running while stopped, frame-aligned while running
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      act_run <= 1'b0;
      act_pal <= '0;
      for (int i = 0; i < 6; i++) act_p[i] <= '0;
    end else begin
      act_run <= pend_run;
      if (!pend_run || frame_start) begin
        act_pal <= pend_pal;
        for (int i = 0; i < 6; i++) act_p[i] <= pend_p[i];
      end
    end
  end

`ifdef FRACTAL_CTRL_FRAME_CNT_EN
  // Count frames started while running; wraps naturally
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                   frame_cnt <= '0;
    else if (frame_start & act_run) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  assign frame_cnt = '0;
`endif

  // Read mux over pending values
  always_comb begin
    rd_val = '0;
    if (rd_idx == 3'd0)
      rd_val = {{(DATA_W-11){1'b0}}, pend_pal, 7'b0, pend_run};
    if (rd_idx == 3'd1)
      rd_val = frame_cnt;
    for (int i = 0; i < 6; i++)
      if (rd_idx == 3'(i + 2)) rd_val = pend_p[i];
  end

  // Read FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_next;
  end

  // Read FSM next state
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (s_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    s_axi_arready = live & (rd_state == R_IDLE);
    s_axi_rvalid  = (rd_state == R_DATA);
  end

  // Read data captured on AR handshake, held until accepted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
    end else if (ar_hs) begin
      s_axi_rdata <= s_axi_araddr[2] ? '0 : rd_val;
      s_axi_rresp <= s_axi_araddr[2] ? 2'b10 : 2'b00;
    end
  end

  assign run     = act_run;
  assign palette = act_pal;
  assign x0      = act_p[0];
  assign y0      = act_p[1];
  assign dx      = act_p[2];
  assign dy      = act_p[3];
  assign cr      = act_p[4];
  assign ci      = act_p[5];

endmodule

// File: tb/tb_fractal_ctrl_axil_slave.sv
// tb_fractal_ctrl_axil_slave: directed vector table plus
// hand sequences for handshake ordering, shadowing and reset.
module tb_fractal_ctrl_axil_slave;

  logic        aclk, aresetn;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready, frame_start, run;
  logic [2:0]  palette;
  logic [31:0] x0, y0, dx, dy, cr, ci;

  int tests = 0;
  int fails = 0;

  fractal_ctrl_axil_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .frame_start(frame_start), .run(run),
    .palette(palette),
    .x0(x0), .y0(y0), .dx(dx), .dy(dy), .cr(cr), .ci(ci)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rd;
  } vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [5:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] r);
    bit af, wf;
    int n;
    r = 2'bxx;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      af = awvalid & awready;
      wf = wvalid & wready;
      tick(1);
      if (af) awvalid = 1'b0;
      if (wf) wvalid = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      awvalid = 1'b0; wvalid = 1'b0;
      check("aw_w_timeout", 32'd1, 32'd0);
      return;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      tick(1);
      n++;
    end
    if (!bvalid) begin
      check("b_timeout", 32'd1, 32'd0);
      return;
    end
    r = bresp;
    tick(1);
  endtask

  task automatic axi_read(input logic [5:0] a,
                          output logic [31:0] d,
                          output logic [1:0] r);
    bit af;
    int n;
    d = 'x; r = 2'bxx;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      af = arvalid & arready;
      tick(1);
      if (af) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin
      arvalid = 1'b0;
      check("ar_timeout", 32'd1, 32'd0);
      return;
    end
    n = 0;
    while (!rvalid && n < 20) begin
      tick(1);
      n++;
    end
    if (!rvalid) begin
      check("r_timeout", 32'd1, 32'd0);
      return;
    end
    d = rdata; r = rresp;
    tick(1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick(3);
    aresetn = 1'b1;
    tick(2);
  endtask

  vec_t        vecs[$];
  logic [31:0] d;
  logic [1:0]  r;
  bit          bad;

  initial begin
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0;
    wvalid = 0; bready = 1; araddr = '0; arvalid = 0;
    rready = 1; frame_start = 0; aresetn = 0;

    // reset values
    tick(2);
    check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    aresetn = 1;
    tick(2);
    check("rst_outs", x0 | y0 | dx | dy | cr | ci, 32'd0);
    check("rst_ctl", {28'd0, palette, run}, 32'd0);

    for (int i = 0; i < 8; i++)
      vecs.push_back('{0, 6'(8 * i), 0, 0, 2'b00, 32'h0});
    vecs.push_back('{1, 6'h10, 32'h10000000, 4'hF, 2'b00, 0});
    vecs.push_back('{1, 6'h18, 32'h09000000, 4'hF, 2'b00, 0});
    vecs.push_back('{1, 6'h30, 32'hF9999999, 4'hF, 2'b00, 0});
    vecs.push_back('{0, 6'h10, 0, 0, 2'b00, 32'h10000000});
    vecs.push_back('{0, 6'h30, 0, 0, 2'b00, 32'hF9999999});
    vecs.push_back('{1, 6'h3C, 32'hDEADBEEF, 4'hF, 2'b10, 0});
    vecs.push_back('{0, 6'h04, 0, 0, 2'b10, 32'h0});
    vecs.push_back('{0, 6'h38, 0, 0, 2'b00, 32'h0});
    vecs.push_back('{0, 6'h30, 0, 0, 2'b00, 32'hF9999999});
    vecs.push_back('{1, 6'h20, 32'h12345678, 4'hF, 2'b00, 0});
    vecs.push_back('{1, 6'h20, 32'hAAAABBBB, 4'h3, 2'b00, 0});
    vecs.push_back('{0, 6'h20, 0, 0, 2'b00, 32'h1234BBBB});
    vecs.push_back('{1, 6'h28, 32'hFFFFFFFF, 4'h0, 2'b00, 0});
    vecs.push_back('{0, 6'h28, 0, 0, 2'b00, 32'h0});
    vecs.push_back('{1, 6'h08, 32'h00000005, 4'hF, 2'b10, 0});
    vecs.push_back('{0, 6'h08, 0, 0, 2'b00, 32'h0});
    vecs.push_back('{1, 6'h00, 32'hFFFFF600, 4'hF, 2'b00, 0});
    vecs.push_back('{0, 6'h00, 0, 0, 2'b00, 32'h00000600});
    vecs.push_back('{1, 6'h0C, 32'h1, 4'hF, 2'b10, 0});
    vecs.push_back('{0, 6'h3C, 0, 0, 2'b10, 32'h0});

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        check($sformatf("vec%0d bresp", i), 32'(r), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d rresp", i), 32'(r), 32'(vecs[i].resp));
        check($sformatf("vec%0d rdata", i), d, vecs[i].rd);
      end
    end

    // run=0: active copies follow pending
    check("idle_x0", x0, 32'h10000000);
    check("idle_y0", y0, 32'h09000000);
    check("idle_dx", dx, 32'h1234BBBB);
    check("idle_cr", cr, 32'hF9999999);
    check("idle_dy_ci", dy | ci, 32'h0);
    check("idle_ctl", {28'd0, palette, run}, {28'd0, 3'd6, 1'b0});

    // start: run immediate, parameters wait for frame_start
    axi_write(6'h00, 32'h00000701, 4'hF, r);
    check("start_run", {31'd0, run}, 32'd1);
    axi_write(6'h10, 32'h20000000, 4'hF, r);
    tick(3);
    check("shadow_x0_hold", x0, 32'h10000000);
    check("shadow_pal_hold", {29'd0, palette}, 32'd6);
    pulse_frame();
    check("frame_x0", x0, 32'h20000000);
    check("frame_pal", {29'd0, palette}, 32'd7);
    check("frame_run", {31'd0, run}, 32'd1);

    // AW ten cycles before W, bready low five cycles
    bready = 1'b0;
    awaddr = 6'h18; awvalid = 1'b1;
    tick(1);
    awvalid = 1'b0;
    tick(10);
    check("aw_first_nob", {31'd0, bvalid}, 32'd0);
    wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    tick(1);
    wvalid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!bvalid || bresp != 2'b00 || awready || wready)
        bad = 1'b1;
      tick(1);
    end
    check("b_hold", {31'd0, bad}, 32'd0);
    bready = 1'b1;
    tick(1);
    check("b_done", {31'd0, bvalid}, 32'd0);
    axi_read(6'h18, d, r);
    check("aw_first_data", d, 32'h11111111);

    // W before AW
    wdata = 32'h22222222; wstrb = 4'hF; wvalid = 1'b1;
    tick(1);
    wvalid = 1'b0;
    tick(3);
    check("w_first_nob", {31'd0, bvalid}, 32'd0);
    awaddr = 6'h28; awvalid = 1'b1;
    tick(1);
    awvalid = 1'b0;
    check("w_first_b", {31'd0, bvalid}, 32'd1);
    tick(1);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid) bad = 1'b1;
      tick(1);
    end
    check("w_first_single", {31'd0, bad}, 32'd0);
    axi_read(6'h28, d, r);
    check("w_first_data", d, 32'h22222222);

    // same-cycle write and read of 0x30
    araddr = 6'h30; arvalid = 1'b1;
    awaddr = 6'h30; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick(1);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("rw_same_old", rdata, 32'hF9999999);
    check("rw_same_bv", {30'd0, bvalid, rvalid}, 32'd3);
    tick(1);
    axi_read(6'h30, d, r);
    check("rw_same_new", d, 32'h0BADF00D);

    // commit coincident with frame_start
    pulse_frame();
    check("cr_loaded", cr, 32'h0BADF00D);
    awaddr = 6'h30; wdata = 32'h01234567; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; frame_start = 1'b1;
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
    tick(3);
    check("coinc_old", cr, 32'h0BADF00D);
    pulse_frame();
    check("coinc_next", cr, 32'h01234567);
    check("frame_y0", y0, 32'h11111111);

    // stop: run drops, copies track again
    axi_write(6'h00, 32'h00000000, 4'hF, r);
    check("stop_run", {31'd0, run}, 32'd0);
    tick(1);
    check("stop_dy", dy, 32'h22222222);

`ifdef FRACTAL_CTRL_FRAME_CNT_EN
    do_reset();
    axi_write(6'h00, 32'h00000001, 4'hF, r);
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      tick(2);
    end
    axi_write(6'h00, 32'h00000000, 4'hF, r);
    tick(1);
    pulse_frame();
    axi_read(6'h08, d, r);
    check("cnt_value", d, 32'd3);
    check("cnt_resp", 32'(r), 32'd0);
`endif

    // reset mid-read with data pending
    rready = 1'b0;
    araddr = 6'h10; arvalid = 1'b1;
    tick(1);
    arvalid = 1'b0;
    check("mid_rvalid_up", {31'd0, rvalid}, 32'd1);
    aresetn = 1'b0;
    #1;
    check("mid_rvalid_drop", {31'd0, rvalid}, 32'd0);
    check("mid_ready_low", {30'd0, arready, awready}, 32'd0);
    tick(2);
    aresetn = 1'b1;
    rready = 1'b1;
    tick(2);
    axi_read(6'h08, d, r);
    check("post_rst_cnt", d, 32'd0);
    axi_read(6'h10, d, r);
    check("post_rst_x0", d, 32'd0);
    check("post_rst_out", x0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
